// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding and the
// parity function used by both ends of the link.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. The reset value lets
// the output start at the input's idle level so no false edge appears.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB-first, even parity, stop. Each bit is
// sampled once at mid-bit by a bit timer that restarts on every state change.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 par_q, par_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == CNT_MID) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = PARITY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_d   = rx_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
          parity_err_d = par_q ^ parity(shift_q);
          frame_err_d  = ~rx_s;
          state_d      = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // A held-low line must return high before another start is accepted.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the team's UART frame format: 11 bits, LSB-first.
- Frame layout: start bit 0, data[0..7], parity bit = XOR of data bits (even parity), stop bit 1.
- Takes the asynchronous line rx_in, synchronizes it, and samples each bit at mid-bit using a clock-cycle bit timer.
- Presents the received byte with a one-cycle valid strobe plus parity and framing error flags. Sits at the far end of the transmit path.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit. Must be even and ≥4. Mid-bit offset H = CLKS_PER_BIT/2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- rx_in  input  1  asynchronous serial line, idle high
- data_out  output  8  last received byte; held until the next frame completes
- data_valid  output  1  one-cycle pulse when a frame completes (good or errored)
- parity_err  output  1  updated with data_valid; 1 = received parity ≠ ^data_out; held until the next data_valid
- frame_err  output  1  updated with data_valid; 1 = stop bit sampled 0; held until the next data_valid
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, takes priority over everything, valid mid-frame):
  - state=IDLE, bit timer=0, bit index=0, shift register=0.
  - Both synchronizer flops=1.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
- Synchronizer: 2 flops, rx_s = second stage. All decisions use rx_s only.
- Bit timer (cnt) clears on every state transition and increments every clk otherwise.
- Shift register: shifts right, new bit enters at MSB. After 8 data samples, the first bit received sits at bit 0.
- States and transitions:
  - IDLE: rx_s==0 -> START.
  - START: when cnt==H-1, sample rx_s. Sample 1 -> IDLE (glitch rejected, no outputs change). Sample 0 -> DATA.
  - DATA: when cnt==CLKS_PER_BIT-1, shift rx_s in and increment index. After the 8th sample -> PARITY, index=0.
  - PARITY: when cnt==CLKS_PER_BIT-1, capture rx_s as par -> STOP.
  - STOP: when cnt==CLKS_PER_BIT-1, in the same edge:
    - data_out <= shift register
    - data_valid <= 1
    - parity_err <= par ^ (^shift register)
    - frame_err <= ~rx_s
    - Then: rx_s==1 -> IDLE; rx_s==0 -> BREAK.
  - BREAK: wait for rx_s==1 -> IDLE. No new frame is detected while the line is held low.
- data_valid is high exactly one cycle per completed frame and is deasserted the following cycle.
- Latency: edge 0 is the first clk edge that samples rx_in low. data_valid is high in the cycle after edge 2 + H + 10*CLKS_PER_BIT. For CLKS_PER_BIT=16 that is edge 170.
- Back-to-back frames: a start bit arriving immediately after the stop bit is accepted. Entering IDLE and then seeing rx_s==0 goes straight to START with no idle cycle required.
- rx_in changes are only ever seen through rx_s. Behaviour is unaffected by events that occur only between sample points.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: IDLE, START, DATA, PARITY, STOP, BREAK
  - FRAME_BITS=11, DATA_BITS=8
  - the parity function (XOR reduction), also used by the transmitter
- Sub-module uart_sync2: 2-flop synchronizer with a reset value parameter (1 here). Reusable for other async inputs.
- Bit timer and FSM stay in uart_rx.

Test Plan (CLKS_PER_BIT=16, bench drives 16 clk per bit):
- Good frame 0xA5, parity 0, stop 1 -> one data_valid pulse at edge 170; data_out=0xA5; parity_err=0; frame_err=0; busy returns to 0 one cycle later.
- Frame 0x3C with parity bit 1 -> data_valid pulse; data_out=0x3C; parity_err=1; frame_err=0. Flags hold until the next good frame 0x81 (parity 0) clears both.
- Glitch: rx_in low for 4 clocks, then high -> busy high briefly; no data_valid; FSM back in IDLE; data_out unchanged.
- Frame 0x55 with stop bit 0, line then held low for 40 clocks -> data_valid with frame_err=1 and data_out=0x55; no further data_valid while low. A frame 0x12 sent after the line returns high is received correctly.
- Back-to-back 0x00 then 0xFF, zero idle gap -> two data_valid pulses 176 clocks apart; data 0x00 then 0xFF; no errors.
- rst asserted for 1 cycle during DATA of frame 0x77 -> all outputs 0 the next cycle; no data_valid for that frame. A following clean frame 0x77 is received correctly.
